// File: rtl/alarm_ctrl.sv
// alarm_ctrl: BCD alarm time store, time match, ring/snooze/stop FSM and gated buzzer
//
// Ports:
//   CLK, RESET          system clock, asynchronous active-low reset
//   ENABLE, ENABLE_kHz  1 Hz and 1 kHz single-cycle ticks
//   HOU_*/MIN_*/SEC_*   live BCD time of day from the counter chain
//   set_active, sel_min alarm edit mode and field select (0 hour, 1 minute)
//   INC_MODE            increment pulse for the selected alarm field
//   arm_toggle          toggles ARMED; while armed it also forces IDLE
//   stop, snooze        user ring controls
//   ALM_*               alarm BCD digits for the display multiplexer
//   ARMED, RINGING, SNOOZING, BUZZ  status flags and buzzer drive
module alarm_ctrl #(
   parameter int RING_SEC   = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int BUZZ_DIV   = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       ENABLE_kHz,
   input  logic [3:0] HOU_CNT3,
   input  logic [3:0] HOU_CNT10,
   input  logic [3:0] MIN_CNT6,
   input  logic [3:0] MIN_CNT10,
   input  logic [3:0] SEC_CNT6,
   input  logic [3:0] SEC_CNT10,
   input  logic       set_active,
   input  logic       sel_min,
   input  logic       INC_MODE,
   input  logic       arm_toggle,
   input  logic       stop,
   input  logic       snooze,
   output logic [3:0] ALM_HOU_CNT3,
   output logic [3:0] ALM_HOU_CNT10,
   output logic [3:0] ALM_MIN_CNT6,
   output logic [3:0] ALM_MIN_CNT10,
   output logic       ARMED,
   output logic       RINGING,
   output logic       SNOOZING,
   output logic       BUZZ
);
   localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);
   localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);
   localparam logic [3:0]  DIV_LAST  = 4'(BUZZ_DIV - 1);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

   state_t      state, state_nxt;
   logic        match, match_d, trigger, disarm, ring_stay, div_hit, tone;
   logic [7:0]  ring_cnt, hour_inc, min_inc;
   logic [11:0] snz_cnt;
   logic [3:0]  div_cnt;

   // Seconds must be 00 so an edit landing on the current minute cannot fire
   assign match   = {HOU_CNT3, HOU_CNT10, MIN_CNT6, MIN_CNT10} ==
                    {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10} &&
                    SEC_CNT6 == 4'd0 && SEC_CNT10 == 4'd0;
   assign trigger = match & ~match_d & ARMED & ~set_active;
   assign disarm  = arm_toggle & ARMED;

   assign hour_inc = (ALM_HOU_CNT3 == 4'd2 && ALM_HOU_CNT10 == 4'd3) ? 8'h00 :
                     (ALM_HOU_CNT10 == 4'd9) ? {ALM_HOU_CNT3 + 4'd1, 4'd0} :
                     {ALM_HOU_CNT3, ALM_HOU_CNT10 + 4'd1};
   assign min_inc  = (ALM_MIN_CNT10 != 4'd9) ? {ALM_MIN_CNT6, ALM_MIN_CNT10 + 4'd1} :
                     {(ALM_MIN_CNT6 == 4'd5) ? 4'd0 : ALM_MIN_CNT6 + 4'd1, 4'd0};

   always_comb begin
      state_nxt = state;
      if (disarm)
         state_nxt = IDLE;
      else
         case (state)
            IDLE:    state_nxt = trigger ? RING : IDLE;
            RING:    state_nxt = stop ? IDLE : snooze ? SNOOZE :
                                 (ENABLE && ring_cnt == RING_LAST) ? IDLE : RING;
            SNOOZE:  state_nxt = stop ? IDLE :
                                 (ENABLE && snz_cnt == 12'd1) ? RING : SNOOZE;
            default: state_nxt = IDLE;
         endcase
   end

   // Counters and tone only run while RING persists; any exit or entry clears them
   assign ring_stay = state == RING && state_nxt == RING;
   assign div_hit   = div_cnt == DIV_LAST;
   assign BUZZ      = tone & ~ring_cnt[0];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         match_d  <= 1'b0;
         RINGING  <= 1'b0;
         SNOOZING <= 1'b0;
         ring_cnt <= '0;
         snz_cnt  <= '0;
         div_cnt  <= '0;
         tone     <= 1'b0;
      end else begin
         state    <= state_nxt;
         match_d  <= match;
         RINGING  <= state_nxt == RING;
         SNOOZING <= state_nxt == SNOOZE;
         ring_cnt <= ring_stay ? ring_cnt + {7'd0, ENABLE} : '0;
         snz_cnt  <= (state == RING && state_nxt == SNOOZE) ? SNZ_LOAD :
                     (state == SNOOZE && state_nxt == SNOOZE) ? snz_cnt - {11'd0, ENABLE} : '0;
         div_cnt  <= !ring_stay ? '0 : !ENABLE_kHz ? div_cnt : div_hit ? '0 : div_cnt + 4'd1;
         tone     <= ring_stay & (tone ^ (ENABLE_kHz & div_hit));
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         ARMED         <= 1'b0;
         ALM_HOU_CNT3  <= 4'd0;
         ALM_HOU_CNT10 <= 4'd6;
         ALM_MIN_CNT6  <= 4'd0;
         ALM_MIN_CNT10 <= 4'd0;
      end else begin
         ARMED <= ARMED ^ arm_toggle;
         if (set_active && INC_MODE && !sel_min)
            {ALM_HOU_CNT3, ALM_HOU_CNT10} <= hour_inc;
         if (set_active && INC_MODE && sel_min)
            {ALM_MIN_CNT6, ALM_MIN_CNT10} <= min_inc;
      end
   end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed and randomized checks of alarm_ctrl against a seconds-of-day model
module tb_alarm_ctrl;
   localparam int RING_SEC   = 60;
   localparam int SNOOZE_MIN = 5;
   localparam int BUZZ_DIV   = 1;

   logic CLK = 1'b0, RESET = 1'b0;
   logic ENABLE = 1'b0, ENABLE_kHz = 1'b0;
   logic set_active = 1'b0, sel_min = 1'b0, INC_MODE = 1'b0;
   logic arm_toggle = 1'b0, stop = 1'b0, snooze = 1'b0;
   logic [3:0] HOU_CNT3, HOU_CNT10, MIN_CNT6, MIN_CNT10, SEC_CNT6, SEC_CNT10;
   logic [3:0] ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10;
   logic ARMED, RINGING, SNOOZING, BUZZ;

   int t = 0;
   int checks = 0, errors = 0;
   int m_alarm, m_mode, m_ring, m_snz, m_khz;
   bit m_armed, m_mprev;

   assign HOU_CNT3  = 4'(t / 36000);
   assign HOU_CNT10 = 4'((t / 3600) % 10);
   assign MIN_CNT6  = 4'((t / 600) % 6);
   assign MIN_CNT10 = 4'((t / 60) % 10);
   assign SEC_CNT6  = 4'((t % 60) / 10);
   assign SEC_CNT10 = 4'(t % 10);

   alarm_ctrl #(.RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN), .BUZZ_DIV(BUZZ_DIV)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .ENABLE_kHz(ENABLE_kHz),
      .HOU_CNT3(HOU_CNT3), .HOU_CNT10(HOU_CNT10), .MIN_CNT6(MIN_CNT6), .MIN_CNT10(MIN_CNT10),
      .SEC_CNT6(SEC_CNT6), .SEC_CNT10(SEC_CNT10), .set_active(set_active), .sel_min(sel_min),
      .INC_MODE(INC_MODE), .arm_toggle(arm_toggle), .stop(stop), .snooze(snooze),
      .ALM_HOU_CNT3(ALM_HOU_CNT3), .ALM_HOU_CNT10(ALM_HOU_CNT10),
      .ALM_MIN_CNT6(ALM_MIN_CNT6), .ALM_MIN_CNT10(ALM_MIN_CNT10),
      .ARMED(ARMED), .RINGING(RINGING), .SNOOZING(SNOOZING), .BUZZ(BUZZ));

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", tag, got, exp, t, $time);
      end
   endtask

   function automatic logic [15:0] exp_alm();
      int h, m;
      h = m_alarm / 60;
      m = m_alarm % 60;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
   endfunction

   task automatic m_reset();
      m_alarm = 6 * 60;
      m_armed = 0;
      m_mode  = 0;
      m_ring  = 0;
      m_snz   = 0;
      m_khz   = 0;
      m_mprev = 0;
   endtask

   // Modes: 0 idle, 1 ringing, 2 snoozing; alarm kept as minutes of day
   task automatic model_step();
      bit mt, trig;
      int nm, h, m;
      mt   = (t / 60 == m_alarm) && (t % 60 == 0);
      trig = mt && !m_mprev && m_armed && !set_active;
      nm   = m_mode;
      if (arm_toggle && m_armed) nm = 0;
      else if (m_mode == 1) begin
         if (stop) nm = 0;
         else if (snooze) begin
            nm = 2;
            m_snz = SNOOZE_MIN * 60;
         end else if (ENABLE) begin
            m_ring++;
            if (m_ring == RING_SEC) nm = 0;
         end
      end else if (m_mode == 2) begin
         if (stop) nm = 0;
         else if (ENABLE) begin
            m_snz--;
            if (m_snz == 0) begin
               nm = 1;
               m_ring = 0;
            end
         end
      end else if (trig) begin
         nm = 1;
         m_ring = 0;
      end
      m_khz = (nm == 1 && m_mode == 1) ? m_khz + int'(ENABLE_kHz) : 0;
      if (set_active && INC_MODE) begin
         h = m_alarm / 60;
         m = m_alarm % 60;
         m_alarm = sel_min ? h * 60 + (m + 1) % 60 : ((h + 1) % 24) * 60 + m;
      end
      m_armed = m_armed ^ arm_toggle;
      m_mprev = mt;
      m_mode  = nm;
   endtask

   task automatic step();
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      check("alm", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, exp_alm());
      check("armed", 16'(ARMED), 16'(m_armed));
      check("ringing", 16'(RINGING), 16'(m_mode == 1));
      check("snoozing", 16'(SNOOZING), 16'(m_mode == 2));
      check("buzz", 16'(BUZZ), 16'(m_mode == 1 && (m_khz / BUZZ_DIV) % 2 == 1 && m_ring % 2 == 0));
      if (ENABLE) t = (t + 1) % 86400;
      INC_MODE   = 0;
      arm_toggle = 0;
      stop       = 0;
      snooze     = 0;
      ENABLE     = 0;
      ENABLE_kHz = 0;
   endtask

   task automatic inc(input logic field, input int n);
      sel_min = field;
      for (int i = 0; i < n; i++) begin
         INC_MODE = 1;
         step();
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         ENABLE = 1;
         ENABLE_kHz = 1;
         step();
         ENABLE_kHz = 1;
         step();
      end
   endtask

   task automatic to_alarm();
      t = 7 * 3600 + 29 * 60 + 59;
      step();
      ENABLE = 1;
      step();
      step();
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge CLK);
      check("rst_alm", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h0600);
      check("rst_armed", 16'(ARMED), 16'd0);
      check("rst_ring", 16'(RINGING), 16'd0);
      check("rst_buzz", 16'(BUZZ), 16'd0);
      RESET = 1;

      set_active = 1;
      inc(0, 3);
      inc(1, 45);
      check("alm_0945", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h0945);
      inc(1, 15);
      check("alm_0900", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h0900);
      inc(0, 14);
      check("alm_2300", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h2300);
      inc(0, 1);
      check("alm_0000", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h0000);
      inc(0, 7);
      inc(1, 30);
      check("alm_0730", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h0730);
      set_active = 0;

      arm_toggle = 1;
      step();
      to_alarm();
      check("ring_start", 16'(RINGING), 16'd1);
      ticks(59);
      check("ring_hold", 16'(RINGING), 16'd1);
      ticks(1);
      check("ring_timeout", 16'(RINGING), 16'd0);
      check("buzz_after", 16'(BUZZ), 16'd0);

      to_alarm();
      ticks(3);
      stop = 1;
      step();
      ticks(10);
      check("no_retrig", 16'(RINGING), 16'd0);

      to_alarm();
      snooze = 1;
      step();
      check("snz_enter", 16'(SNOOZING), 16'd1);
      check("snz_buzz", 16'(BUZZ), 16'd0);
      ticks(299);
      check("snz_hold", 16'(SNOOZING), 16'd1);
      ticks(1);
      check("snz_wake", 16'(RINGING), 16'd1);
      stop = 1;
      step();

      to_alarm();
      stop = 1;
      snooze = 1;
      step();
      check("stop_snz_ring", 16'(RINGING), 16'd0);
      check("stop_snz_snz", 16'(SNOOZING), 16'd0);
      to_alarm();
      snooze = 1;
      step();
      ticks(3);
      arm_toggle = 1;
      step();
      check("disarm_armed", 16'(ARMED), 16'd0);
      check("disarm_snz", 16'(SNOOZING), 16'd0);

      to_alarm();
      check("unarmed_ring", 16'(RINGING), 16'd0);
      arm_toggle = 1;
      step();
      set_active = 1;
      to_alarm();
      check("setmode_ring", 16'(RINGING), 16'd0);
      inc(0, 17);
      inc(1, 30);
      set_active = 0;
      t = 86399;
      step();
      ENABLE = 1;
      step();
      step();
      check("rollover_ring", 16'(RINGING), 16'd1);
      ENABLE_kHz = 1;
      step();
      check("buzz_on", 16'(BUZZ), 16'd1);

      @(posedge CLK);
      #2 RESET = 0;
      #1;
      check("arst_buzz", 16'(BUZZ), 16'd0);
      check("arst_ring", 16'(RINGING), 16'd0);
      check("arst_armed", 16'(ARMED), 16'd0);
      check("arst_alm", {ALM_HOU_CNT3, ALM_HOU_CNT10, ALM_MIN_CNT6, ALM_MIN_CNT10}, 16'h0600);
      m_reset();
      @(negedge CLK);
      RESET = 1;

      arm_toggle = 1;
      step();
      t = 6 * 3600 - 30;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 199) == 0) set_active = ~set_active;
         sel_min    = 1'($urandom_range(0, 1));
         INC_MODE   = set_active && $urandom_range(0, 15) == 0;
         arm_toggle = $urandom_range(0, 299) == 0;
         stop       = $urandom_range(0, 149) == 0;
         snooze     = $urandom_range(0, 99) == 0;
         ENABLE     = $urandom_range(0, 2) == 0;
         ENABLE_kHz = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 399) == 0) t = (m_alarm * 60 + 86399) % 86400;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
